sha256_req_arbiter: RTL and testbench

SHA256_REQ_ARBITER -- requirements
Module: sha256_req_arbiter

---
 rtl/sha256_defs_pkg.sv | 12 +
 rtl/bsg_fifo_1r1w_small.sv | 53 +++++
 rtl/sha256_req_arbiter.sv | 124 ++++++++++++
 tb/tb_sha256_req_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_defs_pkg.sv
// Shared SHA-256 interface widths and the message arbiter state encoding.
package sha256_defs;

   localparam int unsigned SHA_IF_DATA_W   = 32;
   localparam int unsigned SHA256_DIGEST_W = 256;

   typedef enum logic {
      IDLE,
      STREAM
   } arb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with a combinational head; a push while full
// is honoured when the same cycle also pops.
module bsg_fifo_1r1w_small #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned ELS   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PTR_W = $clog2(ELS);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [ELS];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(ELS));
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sha256_req_arbiter.sv
// Whole-message round-robin arbiter sharing one SHA-256 engine; an owner
// FIFO routes each returned digest back to the requester that sent it.
module sha256_req_arbiter
   import sha256_defs::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ID_FIFO_ELS = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_REQ-1:0]                      req_val,
   input  logic [NUM_REQ-1:0][SHA_IF_DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]                      req_last,
   output logic [NUM_REQ-1:0]                      req_rdy,
   output logic                                    eng_data_val,
   output logic [SHA_IF_DATA_W-1:0]                eng_data,
   output logic                                    eng_data_last,
   input  logic                                    eng_rdy,
   input  logic                                    eng_digest_val,
   input  logic [SHA256_DIGEST_W-1:0]              eng_digest,
   output logic                                    eng_digest_rdy,
   output logic [NUM_REQ-1:0]                      rsp_digest_val,
   output logic [SHA256_DIGEST_W-1:0]              rsp_digest,
   input  logic [NUM_REQ-1:0]                      rsp_digest_rdy,
   output logic                                    err_orphan
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   arb_state_e      state, state_nxt;
   logic [ID_W-1:0] grant, grant_nxt;
   logic [ID_W-1:0] rr_ptr, rr_nxt;
   logic [ID_W-1:0] pick;
   logic [ID_W-1:0] head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;

   // Search upward from rr_ptr+1 so the last-served requester goes last.
   always_comb begin
      logic            found;
      logic [ID_W-1:0] cand;
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = ID_W'((32'(rr_ptr) + off) % NUM_REQ);
         if (!found && req_val[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      rr_nxt        = rr_ptr;
      req_rdy       = '0;
      eng_data_val  = 1'b0;
      eng_data      = '0;
      eng_data_last = 1'b0;
      push          = 1'b0;
      case (state)
         IDLE: begin
            if (|req_val && !fifo_full) begin
               state_nxt = STREAM;
               grant_nxt = pick;
            end
         end
         STREAM: begin
            eng_data_val   = req_val[grant];
            eng_data       = req_data[grant];
            eng_data_last  = req_last[grant];
            req_rdy[grant] = eng_rdy;
            if (req_val[grant] && eng_rdy && req_last[grant]) begin
               push      = 1'b1;
               rr_nxt    = grant;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         rr_ptr     <= ID_W'(NUM_REQ - 1);
         err_orphan <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         rr_ptr     <= rr_nxt;
         err_orphan <= err_orphan | (eng_digest_val & fifo_empty);
      end
   end

   always_comb begin
      rsp_digest_val = '0;
      if (eng_digest_val && !fifo_empty) rsp_digest_val[head] = 1'b1;
   end

   assign eng_digest_rdy = ~fifo_empty & rsp_digest_rdy[head];
   assign pop            = eng_digest_val & eng_digest_rdy;
   assign rsp_digest     = eng_digest;

   bsg_fifo_1r1w_small #(
      .WIDTH (ID_W),
      .ELS   (ID_FIFO_ELS)
   ) owner_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (grant),
      .full      (fifo_full),
      .pop       (pop),
      .empty     (fifo_empty),
      .head      (head)
   );

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Bench for sha256_req_arbiter: message-level round-robin model feeding beat
// and owner scoreboards, a STREAM pass-through table, and hand-built corner cases.
module tb_sha256_req_arbiter;
   import sha256_defs::*;

   localparam int unsigned NR  = 4;
   localparam int unsigned ELS = 4;
   localparam int unsigned IW  = $clog2(NR);
   typedef logic [IW-1:0] idx_t;

   logic                              clk;
   logic                              rst;
   logic [NR-1:0]                     req_val;
   logic [NR-1:0][SHA_IF_DATA_W-1:0]  req_data;
   logic [NR-1:0]                     req_last;
   logic [NR-1:0]                     req_rdy;
   logic                              eng_data_val;
   logic [SHA_IF_DATA_W-1:0]          eng_data;
   logic                              eng_data_last;
   logic                              eng_rdy;
   logic                              eng_digest_val;
   logic [SHA256_DIGEST_W-1:0]        eng_digest;
   logic                              eng_digest_rdy;
   logic [NR-1:0]                     rsp_digest_val;
   logic [SHA256_DIGEST_W-1:0]        rsp_digest;
   logic [NR-1:0]                     rsp_digest_rdy;
   logic                              err_orphan;

   sha256_req_arbiter #(
      .NUM_REQ     (NR),
      .ID_FIFO_ELS (ELS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_val        (req_val),
      .req_data       (req_data),
      .req_last       (req_last),
      .req_rdy        (req_rdy),
      .eng_data_val   (eng_data_val),
      .eng_data       (eng_data),
      .eng_data_last  (eng_data_last),
      .eng_rdy        (eng_rdy),
      .eng_digest_val (eng_digest_val),
      .eng_digest     (eng_digest),
      .eng_digest_rdy (eng_digest_rdy),
      .rsp_digest_val (rsp_digest_val),
      .rsp_digest     (rsp_digest),
      .rsp_digest_rdy (rsp_digest_rdy),
      .err_orphan     (err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0]   data;
      logic          last;
      logic [NR-1:0] rdy;
   } beat_t;

   typedef struct packed {
      logic [NR-1:0] val;
      logic [NR-1:0] last;
      logic          rdy;
      logic [NR-1:0] x_rdy;
      logic          x_val;
      logic          x_last;
   } vec_t;

   beat_t       beat_q[$];
   idx_t        owner_q[$];
   int unsigned beat_cyc[$];
   int          n_cmp   = 0;
   int          n_bad   = 0;
   int          n_beats = 0;
   int          n_dig   = 0;
   int          dig_seq = 0;
   int unsigned drv_start = 0;
   int          rr_m = NR - 1;

   int msgs_left [NR];
   int msg_len   [NR];
   int msg_no    [NR];
   int beat_no   [NR];

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_data(input int r, input int m, input int b);
      return {8'(r), 8'(m), 16'(b)};
   endfunction

   function automatic logic [NR-1:0] oh(input int r);
      return NR'(1) << r;
   endfunction

   function automatic bit all_done();
      for (int i = 0; i < NR; i++) if (msgs_left[idx_t'(i)] > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic offer(input int r, input int n, input int len);
      msgs_left[idx_t'(r)] = n;
      msg_len[idx_t'(r)]   = len;
      msg_no[idx_t'(r)]    = 0;
      beat_no[idx_t'(r)]   = 0;
   endtask

   // Message-level arbiter model: every offered message is pending from the start.
   task automatic plan();
      int left [NR];
      int mcnt [NR];
      int r;
      bit any;
      for (int i = 0; i < NR; i++) begin
         left[idx_t'(i)] = msgs_left[idx_t'(i)];
         mcnt[idx_t'(i)] = msg_no[idx_t'(i)];
      end
      any = 1'b1;
      while (any) begin
         any = 1'b0;
         r   = 0;
         for (int off = 1; off <= NR && !any; off++) begin
            r = (rr_m + off) % NR;
            if (left[idx_t'(r)] > 0) any = 1'b1;
         end
         if (any) begin
            for (int b = 0; b < msg_len[idx_t'(r)]; b++)
               beat_q.push_back({mk_data(r, mcnt[idx_t'(r)], b), b == msg_len[idx_t'(r)] - 1, oh(r)});
            owner_q.push_back(idx_t'(r));
            left[idx_t'(r)]--;
            mcnt[idx_t'(r)]++;
            rr_m = r;
         end
      end
   endtask

   task automatic drive_outputs();
      for (int i = 0; i < NR; i++) begin
         req_val[idx_t'(i)]  = msgs_left[idx_t'(i)] > 0;
         req_data[idx_t'(i)] = mk_data(i, msg_no[idx_t'(i)], beat_no[idx_t'(i)]);
         req_last[idx_t'(i)] = beat_no[idx_t'(i)] == msg_len[idx_t'(i)] - 1;
      end
   endtask

   task automatic run_driver(input int max_cyc, input bit need_done);
      logic [NR-1:0] acc;
      bit done;
      @(posedge clk); #1;
      drive_outputs();
      drv_start = cyc;
      done = all_done();
      for (int c = 0; c < max_cyc && !done; c++) begin
         @(negedge clk);
         acc = req_val & req_rdy;
         @(posedge clk); #1;
         for (int i = 0; i < NR; i++) begin
            if (acc[idx_t'(i)]) begin
               if (beat_no[idx_t'(i)] == msg_len[idx_t'(i)] - 1) begin
                  beat_no[idx_t'(i)] = 0;
                  msg_no[idx_t'(i)]++;
                  msgs_left[idx_t'(i)]--;
               end else begin
                  beat_no[idx_t'(i)]++;
               end
            end
         end
         drive_outputs();
         done = all_done();
      end
      if (need_done) chk("driver_done", 256'(done), 256'(1));
   endtask

   task automatic give_digest();
      bit ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         ok = eng_digest_rdy;
      end
      chk("digest_ready_wait", 256'(ok), 256'(1));
      if (ok) begin
         @(posedge clk); #1;
         eng_digest_val = 1'b1;
         eng_digest     = {8{32'hC0DE_0000 + 32'(dig_seq)}};
         dig_seq++;
         @(posedge clk); #1;
         eng_digest_val = 1'b0;
      end
   endtask

   task automatic do_reset(input bit check);
      @(posedge clk); #1;
      rst            = 1'b1;
      req_val        = '0;
      req_last       = '0;
      req_data       = '0;
      eng_rdy        = 1'b1;
      eng_digest_val = 1'b0;
      eng_digest     = '0;
      rsp_digest_rdy = '1;
      for (int i = 0; i < NR; i++) offer(i, 0, 1);
      @(posedge clk); #1;
      if (check) begin
         @(negedge clk);
         chk("rst_req_rdy",        256'(req_rdy),        256'(0));
         chk("rst_eng_data_val",   256'(eng_data_val),   256'(0));
         chk("rst_rsp_digest_val", 256'(rsp_digest_val), 256'(0));
         chk("rst_eng_digest_rdy", 256'(eng_digest_rdy), 256'(0));
         chk("rst_err_orphan",     256'(err_orphan),     256'(0));
         @(posedge clk); #1;
      end
      rst  = 1'b0;
      rr_m = NR - 1;
   endtask

   // Engine-side beat scoreboard.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst && eng_data_val && eng_rdy) begin
            chk("beat_expected", 256'(beat_q.size() != 0), 256'(1));
            if (beat_q.size() != 0) begin
               e = beat_q.pop_front();
               chk("beat_data", 256'(eng_data),      256'(e.data));
               chk("beat_last", 256'(eng_data_last), 256'(e.last));
               chk("beat_rdy",  256'(req_rdy),       256'(e.rdy));
            end
            beat_cyc.push_back(cyc);
            n_beats++;
         end
      end
   end

   // Digest routing scoreboard.
   initial begin
      idx_t o;
      forever begin
         @(negedge clk);
         if (!rst && eng_digest_val && eng_digest_rdy) begin
            chk("digest_expected", 256'(owner_q.size() != 0), 256'(1));
            if (owner_q.size() != 0) begin
               o = owner_q.pop_front();
               chk("digest_owner", 256'(rsp_digest_val), 256'(oh(int'(o))));
               chk("digest_bus",   rsp_digest,           eng_digest);
            end
            n_dig++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [7];
      int   base;
      int   dbase;

      // grant held by requester 2 during the table
      tbl[0] = '{val: 4'b0100, last: 4'b0000, rdy: 1'b1, x_rdy: 4'b0100, x_val: 1'b1, x_last: 1'b0};
      tbl[1] = '{val: 4'b0000, last: 4'b0000, rdy: 1'b1, x_rdy: 4'b0100, x_val: 1'b0, x_last: 1'b0};
      tbl[2] = '{val: 4'b1011, last: 4'b1011, rdy: 1'b1, x_rdy: 4'b0100, x_val: 1'b0, x_last: 1'b0};
      tbl[3] = '{val: 4'b0100, last: 4'b0100, rdy: 1'b0, x_rdy: 4'b0000, x_val: 1'b1, x_last: 1'b1};
      tbl[4] = '{val: 4'b1111, last: 4'b0000, rdy: 1'b0, x_rdy: 4'b0000, x_val: 1'b1, x_last: 1'b0};
      tbl[5] = '{val: 4'b0100, last: 4'b1011, rdy: 1'b1, x_rdy: 4'b0100, x_val: 1'b1, x_last: 1'b0};
      tbl[6] = '{val: 4'b1111, last: 4'b0100, rdy: 1'b0, x_rdy: 4'b0000, x_val: 1'b1, x_last: 1'b1};

      rst = 1'b1; req_val = '0; req_last = '0; req_data = '0; eng_rdy = 1'b1;
      eng_digest_val = 1'b0; eng_digest = '0; rsp_digest_rdy = '1;
      for (int i = 0; i < NR; i++) offer(i, 0, 1);

      // Reset state, then STREAM pass-through table for requester 2
      do_reset(1'b1);
      @(posedge clk); #1;
      req_val = 4'b0100; req_last = '0; eng_rdy = 1'b0;
      for (int i = 0; i < NR; i++) req_data[idx_t'(i)] = mk_data(i, 'hA0, 0);
      @(negedge clk);
      chk("tbl_bubble_val", 256'(eng_data_val), 256'(0));
      chk("tbl_bubble_rdy", 256'(req_rdy),      256'(0));
      @(posedge clk); #1;
      for (int v = 0; v < 7; v++) begin
         req_val  = tbl[v].val;
         req_last = tbl[v].last;
         eng_rdy  = tbl[v].rdy;
         for (int i = 0; i < NR; i++) req_data[idx_t'(i)] = mk_data(i, 'hA0, v + 1);
         if (tbl[v].val[2] && tbl[v].rdy)
            beat_q.push_back({mk_data(2, 'hA0, v + 1), tbl[v].last[2], 4'b0100});
         @(negedge clk);
         chk("tbl_req_rdy",   256'(req_rdy),       256'(tbl[v].x_rdy));
         chk("tbl_eng_val",   256'(eng_data_val),  256'(tbl[v].x_val));
         chk("tbl_eng_last",  256'(eng_data_last), 256'(tbl[v].x_last));
         chk("tbl_eng_data",  256'(eng_data),      256'(mk_data(2, 'hA0, v + 1)));
         @(posedge clk); #1;
      end
      req_val = 4'b0100; req_last = 4'b0100; eng_rdy = 1'b1;
      req_data[2] = mk_data(2, 'hA0, 8);
      beat_q.push_back({mk_data(2, 'hA0, 8), 1'b1, 4'b0100});
      owner_q.push_back(idx_t'(2));
      @(posedge clk); #1;
      req_val = '0; req_last = '0;
      @(negedge clk);
      chk("tbl_back_idle_val", 256'(eng_data_val), 256'(0));
      chk("tbl_back_idle_rdy", 256'(req_rdy),      256'(0));
      give_digest();
      rr_m = 2;

      // Single requester 1, three beats: bubble then back-to-back beats
      offer(1, 1, 3);
      plan();
      beat_cyc.delete();
      run_driver(30, 1'b1);
      give_digest();
      chk("t1_beat_count",    256'(beat_cyc.size()),           256'(3));
      chk("t1_first_latency", 256'(beat_cyc[0] - drv_start),   256'(1));
      chk("t1_last_latency",  256'(beat_cyc[2] - drv_start),   256'(3));

      // All requesters valid, single-beat messages: order 0,1,2,3,0
      do_reset(1'b0);
      offer(0, 2, 1); offer(1, 1, 1); offer(2, 1, 1); offer(3, 1, 1);
      plan();
      dbase = n_dig;
      fork
         run_driver(200, 1'b1);
         begin
            repeat (5) give_digest();
         end
      join
      chk("t2_digests", 256'(n_dig - dbase), 256'(5));

      // Owner FIFO full blocks the fifth grant; held digest handshake
      do_reset(1'b0);
      offer(0, 2, 1); offer(1, 1, 1); offer(2, 1, 1); offer(3, 1, 1);
      plan();
      base = n_beats;
      run_driver(20, 1'b0);
      chk("t3_granted_until_full", 256'(n_beats - base), 256'(4));
      @(negedge clk);
      chk("t3_blocked_val",   256'(eng_data_val),   256'(0));
      chk("t3_blocked_rdy",   256'(req_rdy),        256'(0));
      chk("t3_full_head_rdy", 256'(eng_digest_rdy), 256'(1));
      fork
         run_driver(60, 1'b1);
         give_digest();
      join
      chk("t3_fifth_granted", 256'(n_beats - base), 256'(5));
      dbase = n_dig;
      @(posedge clk); #1;
      rsp_digest_rdy = 4'b1101;
      eng_digest_val = 1'b1;
      eng_digest     = {8{32'hBEEF_0001}};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("t3_hold_eng_rdy", 256'(eng_digest_rdy), 256'(0));
         chk("t3_hold_rsp_val", 256'(rsp_digest_val), 256'(4'b0010));
         @(posedge clk); #1;
      end
      rsp_digest_rdy = '1;
      @(negedge clk);
      chk("t3_release_rdy", 256'(eng_digest_rdy), 256'(1));
      @(posedge clk); #1;
      eng_digest_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_delivered_once", 256'(n_dig - dbase), 256'(1));
      repeat (3) give_digest();

      // Orphan digest with an empty owner FIFO
      @(posedge clk); #1;
      eng_digest_val = 1'b1;
      eng_digest     = {8{32'hDEAD_0000}};
      @(negedge clk);
      chk("orphan_rdy",      256'(eng_digest_rdy), 256'(0));
      chk("orphan_rsp_val",  256'(rsp_digest_val), 256'(0));
      chk("orphan_flag_pre", 256'(err_orphan),     256'(0));
      @(posedge clk); #1;
      eng_digest_val = 1'b0;
      @(negedge clk);
      chk("orphan_flag_set", 256'(err_orphan), 256'(1));
      repeat (5) @(negedge clk);
      chk("orphan_flag_sticky", 256'(err_orphan), 256'(1));

      // Reset clears the flag; then reset in the middle of requester 2's message
      do_reset(1'b1);
      @(posedge clk); #1;
      req_val = 4'b0100; req_last = '0; req_data[2] = mk_data(2, 0, 0);
      beat_q.push_back({mk_data(2, 0, 0), 1'b0, 4'b0100});
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_data[2] = mk_data(2, 0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req_val = '0;
      @(negedge clk);
      chk("midrst_req_rdy",        256'(req_rdy),        256'(0));
      chk("midrst_eng_data_val",   256'(eng_data_val),   256'(0));
      chk("midrst_eng_digest_rdy", 256'(eng_digest_rdy), 256'(0));
      chk("midrst_rsp_digest_val", 256'(rsp_digest_val), 256'(0));
      rr_m = NR - 1;
      offer(0, 1, 1); offer(2, 1, 2);
      plan();
      fork
         run_driver(60, 1'b1);
         begin
            repeat (2) give_digest();
         end
      join

      repeat (3) @(negedge clk);
      chk("end_beats_drained",  256'(beat_q.size()),  256'(0));
      chk("end_owners_drained", 256'(owner_q.size()), 256'(0));
      chk("end_orphan_clear",   256'(err_orphan),     256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
